// File: rtl/sobel_pkg.sv
// Shared types and constants for the 3x3 window frame controller.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        FINISH
    } state_t;

    localparam int WIN_SIZE = 9;
    localparam int MIN_DIM  = 3;

    function automatic logic [31:0] pix_addr(
        input logic [7:0]  base,
        input logic [11:0] row,
        input logic [11:0] w,
        input logic [11:0] col
    );
        return {24'd0, base} + ({20'd0, row} * {20'd0, w}) + {20'd0, col};
    endfunction

endpackage

// File: rtl/frame_controller_if.sv
// Read/write request-acknowledge bus between the frame controller and memory.
interface frame_controller_if;

    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic        wr_ack;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr,
        input  rd_ack, wr_ack
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr,
        output rd_ack, wr_ack
    );

endinterface

// File: rtl/frame_controller_pixel_cursor.sv
// Output-pixel and window cursor; yields the next read address and the
// current write address so the controller can register them directly.
module pixel_cursor
    import sobel_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        step_win,
    input  logic        step_px,
    input  logic [11:0] width,
    input  logic [11:0] length,
    input  logic [7:0]  base_r,
    input  logic [7:0]  base_w,
    output logic [31:0] rd_win,
    output logic [31:0] rd_px,
    output logic [31:0] wr_cur,
    output logic        last_win,
    output logic        last_px
);

    logic [11:0] x, y, nx, ny;
    logic [1:0]  kr, kc, nkr, nkc;
    logic [3:0]  k;

    always_comb begin
        nkc = (kc == 2'd2) ? 2'd0 : kc + 2'd1;
        nkr = (kc == 2'd2) ? kr + 2'd1 : kr;
        nx  = (x == width - 12'd2) ? 12'd1 : x + 12'd1;
        ny  = (x == width - 12'd2) ? y + 12'd1 : y;
    end

    assign last_win = (k == 4'(WIN_SIZE - 1));
    assign last_px  = (x == width - 12'd2) && (y == length - 12'd2);

    // Window origin is (x-1, y-1); kr/kc walk the 3x3 neighbourhood.
    assign rd_win = pix_addr(base_r, y - 12'd1 + {10'd0, nkr},
                             width, x - 12'd1 + {10'd0, nkc});
    assign rd_px  = pix_addr(base_r, ny - 12'd1, width, nx - 12'd1);
    assign wr_cur = pix_addr(base_w, y - 12'd1, width - 12'd2, x - 12'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x  <= '0;
            y  <= '0;
            kr <= '0;
            kc <= '0;
            k  <= '0;
        end else if (init) begin
            x  <= 12'd1;
            y  <= 12'd1;
            kr <= '0;
            kc <= '0;
            k  <= '0;
        end else if (step_win) begin
            kr <= nkr;
            kc <= nkc;
            k  <= k + 4'd1;
        end else if (step_px) begin
            x  <= nx;
            y  <= ny;
            kr <= '0;
            kc <= '0;
            k  <= '0;
        end
    end

endmodule

// File: rtl/frame_controller.sv
// Frame controller: streams 3x3 read windows and one write per output pixel.
// Optional FRAME_CTRL_PERF_CNT_EN adds a busy-cycle counter output.
module frame_controller
    import sobel_pkg::*;
(
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               start,
    input  logic [11:0]        width,
    input  logic [11:0]        length,
    input  logic [7:0]         initial_addr_r,
    input  logic [7:0]         initial_addr_w,
    frame_controller_if.master mem,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef FRAME_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]        cycle_count
`endif
);

    state_t      state;
    logic [11:0] w_q, l_q;
    logic [7:0]  br_q, bw_q;
    logic [31:0] rd_win, rd_px, wr_cur;
    logic        last_win, last_px;
    logic        dims_ok, accept, step_win, step_px;

    assign dims_ok  = (width >= 12'(MIN_DIM)) && (length >= 12'(MIN_DIM));
    assign accept   = (state == IDLE) && start && dims_ok;
    assign step_win = (state == READ) && mem.rd_ack && !last_win;
    assign step_px  = (state == WRITE) && mem.wr_ack && !last_px;

    pixel_cursor u_cursor (
        .clk      (HCLK),
        .rst_n    (HRESET),
        .init     (accept),
        .step_win (step_win),
        .step_px  (step_px),
        .width    (w_q),
        .length   (l_q),
        .base_r   (br_q),
        .base_w   (bw_q),
        .rd_win   (rd_win),
        .rd_px    (rd_px),
        .wr_cur   (wr_cur),
        .last_win (last_win),
        .last_px  (last_px)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            state       <= IDLE;
            w_q         <= '0;
            l_q         <= '0;
            br_q        <= '0;
            bw_q        <= '0;
            mem.rd_req  <= 1'b0;
            mem.rd_addr <= '0;
            mem.wr_req  <= 1'b0;
            mem.wr_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    w_q  <= width;
                    l_q  <= length;
                    br_q <= initial_addr_r;
                    bw_q <= initial_addr_w;
                    if (!dims_ok) begin
                        err <= 1'b1;
                    end else begin
                        state       <= READ;
                        busy        <= 1'b1;
                        mem.rd_req  <= 1'b1;
                        mem.rd_addr <= {24'd0, initial_addr_r};
                    end
                end
                READ: if (mem.rd_ack) begin
                    if (last_win) begin
                        state       <= WRITE;
                        mem.rd_req  <= 1'b0;
                        mem.wr_req  <= 1'b1;
                        mem.wr_addr <= wr_cur;
                    end else begin
                        mem.rd_addr <= rd_win;
                    end
                end
                WRITE: if (mem.wr_ack) begin
                    mem.wr_req <= 1'b0;
                    if (last_px) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state       <= READ;
                        mem.rd_req  <= 1'b1;
                        mem.rd_addr <= rd_px;
                    end
                end
                FINISH: state <= IDLE;
            endcase
        end
    end

`ifdef FRAME_CTRL_PERF_CNT_EN
    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            cycle_count <= '0;
        end else if (accept) begin
            cycle_count <= '0;
        end else if (busy) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_controller.sv
// Bench for frame_controller: table jobs, random jobs vs. a frame model,
// plus reset and busy-restart sequences.
module tb_frame_controller;

    logic        HCLK;
    logic        HRESET;
    logic        start;
    logic [11:0] width;
    logic [11:0] length;
    logic [7:0]  initial_addr_r;
    logic [7:0]  initial_addr_w;
    logic        busy;
    logic        done;
    logic        err;
`ifdef FRAME_CTRL_PERF_CNT_EN
    logic [31:0] cycle_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    frame_controller_if mif ();

    frame_controller dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .start          (start),
        .width          (width),
        .length         (length),
        .initial_addr_r (initial_addr_r),
        .initial_addr_w (initial_addr_w),
        .mem            (mif),
        .busy           (busy),
        .done           (done),
        .err            (err)
`ifdef FRAME_CTRL_PERF_CNT_EN
        ,
        .cycle_count    (cycle_count)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        int          w;
        int          l;
        logic [7:0]  br;
        logic [7:0]  bw;
        int          dmin;
        int          dmax;
        bit          poke;
        int          nrd;
        int          nwr;
        logic [31:0] lrd;
        logic [31:0] lwr;
    } vec_t;

    function automatic void check(input string name,
                                  input logic [31:0] got,
                                  input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_req"}, {31'd0, mif.rd_req}, 32'd0);
        check({tag, "_wr_req"}, {31'd0, mif.wr_req}, 32'd0);
        check({tag, "_rd_addr"}, mif.rd_addr, 32'd0);
        check({tag, "_wr_addr"}, mif.wr_addr, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
`ifdef FRAME_CTRL_PERF_CNT_EN
        check({tag, "_cycle_count"}, cycle_count, 32'd0);
`endif
    endtask

    // Runs one job with a randomised responder, checking every request
    // against a frame-walk model built from plain loops.
    task automatic run_job(input int w, input int l,
                           input logic [7:0] br, input logic [7:0] bw,
                           input int dmin, input int dmax, input bit poke,
                           output int nrd, output int nwr,
                           output logic [31:0] last_rd,
                           output logic [31:0] last_wr);
        logic [31:0] rq[$];
        logic [31:0] wq[$];
        logic [31:0] hold, cur, exp;
        logic [1:0]  kind;
        bit          exp_err, pend, fin;
        int          ri, wi, dly, bcyc, cyc;

        for (int y = 1; y <= l - 2; y++)
            for (int x = 1; x <= w - 2; x++) begin
                for (int r = -1; r <= 1; r++)
                    for (int c = -1; c <= 1; c++)
                        rq.push_back(32'(br) + 32'((y + r) * w + (x + c)));
                wq.push_back(32'(bw) + 32'((y - 1) * (w - 2) + (x - 1)));
            end
        exp_err = (w < 3) || (l < 3);
        nrd = 0; nwr = 0; last_rd = '0; last_wr = '0;

        @(negedge HCLK);
        start = 1'b1;
        width = 12'(w);
        length = 12'(l);
        initial_addr_r = br;
        initial_addr_w = bw;
        @(negedge HCLK);
        start = 1'b0;

        if (exp_err) begin
            check("err_pulse", {31'd0, err}, 32'd1);
            check("err_busy", {31'd0, busy}, 32'd0);
            check("err_no_req", {30'd0, mif.rd_req, mif.wr_req}, 32'd0);
            for (int i = 0; i < 4; i++) begin
                @(negedge HCLK);
                check("err_one_cycle", {31'd0, err}, 32'd0);
                check("err_idle", {29'd0, mif.rd_req, mif.wr_req, busy}, 32'd0);
            end
            return;
        end

        pend = 0; fin = 0; ri = 0; wi = 0; bcyc = 0; cyc = 0;
        hold = '0; kind = '0; dly = 0;
        while (cyc < 20000 && !fin) begin
            if (cyc > 0) @(negedge HCLK);
            mif.rd_ack = 1'b0;
            mif.wr_ack = 1'b0;
            if (poke && cyc == 3) begin
                start = 1'b1;
                width = 12'(w + 3);
            end else if (poke && cyc == 4) begin
                start = 1'b0;
                width = 12'(w);
            end
            check("req_exclusive", {31'd0, mif.rd_req && mif.wr_req}, 32'd0);
            if (busy) bcyc++;
            if (done) begin
                fin = 1;
                check("done_reads", 32'(ri), 32'(rq.size()));
                check("done_writes", 32'(wi), 32'(wq.size()));
                check("done_busy", {31'd0, busy}, 32'd0);
`ifdef FRAME_CTRL_PERF_CNT_EN
                check("cycle_count", cycle_count, 32'(bcyc));
`endif
            end else if (mif.rd_req || mif.wr_req) begin
                cur = mif.rd_req ? mif.rd_addr : mif.wr_addr;
                if (!pend) begin
                    pend = 1;
                    hold = cur;
                    kind = {mif.rd_req, mif.wr_req};
                    dly = $urandom_range(dmax, dmin);
                end else begin
                    check("hold_addr", cur, hold);
                    check("hold_req", {30'd0, mif.rd_req, mif.wr_req},
                          {30'd0, kind});
                end
                check("busy_req", {31'd0, busy}, 32'd1);
                if (dly == 0) begin
                    pend = 0;
                    if (mif.rd_req) begin
                        mif.rd_ack = 1'b1;
                        mif.wr_ack = 1'($urandom_range(1, 0));
                        exp = (ri < rq.size()) ? rq[ri] : 32'hxxxxxxxx;
                        check("rd_addr", mif.rd_addr, exp);
                        last_rd = mif.rd_addr;
                        ri++;
                    end else begin
                        mif.wr_ack = 1'b1;
                        mif.rd_ack = 1'($urandom_range(1, 0));
                        exp = (wi < wq.size()) ? wq[wi] : 32'hxxxxxxxx;
                        check("wr_addr", mif.wr_addr, exp);
                        last_wr = mif.wr_addr;
                        wi++;
                    end
                end else begin
                    dly--;
                    if (mif.rd_req) mif.wr_ack = 1'($urandom_range(1, 0));
                    else            mif.rd_ack = 1'($urandom_range(1, 0));
                end
            end else begin
                check("req_present", {31'd0, mif.rd_req || mif.wr_req}, 32'd1);
            end
            cyc++;
        end
        start = 1'b0;
        check("job_timeout", {31'd0, fin}, 32'd1);
        @(negedge HCLK);
        mif.rd_ack = 1'b0;
        mif.wr_ack = 1'b0;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_after_done", {29'd0, busy, mif.rd_req, mif.wr_req}, 32'd0);
        nrd = ri;
        nwr = wi;
    endtask

    initial begin
        vec_t        tbl[8];
        int          nrd, nwr, w, l;
        logic [31:0] lrd, lwr;

        tbl[0] = '{3, 3, 8'h10, 8'h80, 0, 0, 1'b0, 9, 1, 32'h18, 32'h80};
        tbl[1] = '{4, 3, 8'h00, 8'h40, 0, 0, 1'b0, 18, 2, 32'h0B, 32'h41};
        tbl[2] = '{2, 5, 8'h10, 8'h80, 0, 0, 1'b0, 0, 0, 32'h0, 32'h0};
        tbl[3] = '{5, 2, 8'h10, 8'h80, 0, 0, 1'b0, 0, 0, 32'h0, 32'h0};
        tbl[4] = '{3, 3, 8'h10, 8'h80, 5, 5, 1'b0, 9, 1, 32'h18, 32'h80};
        tbl[5] = '{4, 4, 8'h20, 8'h30, 0, 2, 1'b1, 36, 4, 32'h2F, 32'h33};
        tbl[6] = '{5, 4, 8'hF0, 8'hFF, 0, 3, 1'b0, 54, 6, 32'h103, 32'h104};
        tbl[7] = '{3, 5, 8'h01, 8'h02, 1, 2, 1'b0, 27, 3, 32'h0F, 32'h04};

        HRESET = 1'b0;
        start = 1'b0;
        width = '0;
        length = '0;
        initial_addr_r = '0;
        initial_addr_w = '0;
        mif.rd_ack = 1'b0;
        mif.wr_ack = 1'b0;
        repeat (3) @(negedge HCLK);
        check_idle_outputs("reset");
        HRESET = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_job(tbl[i].w, tbl[i].l, tbl[i].br, tbl[i].bw,
                    tbl[i].dmin, tbl[i].dmax, tbl[i].poke,
                    nrd, nwr, lrd, lwr);
            check($sformatf("tbl%0d_nrd", i), 32'(nrd), 32'(tbl[i].nrd));
            check($sformatf("tbl%0d_nwr", i), 32'(nwr), 32'(tbl[i].nwr));
            check($sformatf("tbl%0d_lrd", i), lrd, tbl[i].lrd);
            check($sformatf("tbl%0d_lwr", i), lwr, tbl[i].lwr);
        end

        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(7, 1);
            l = $urandom_range(7, 1);
            run_job(w, l, 8'($urandom), 8'($urandom), 0, 3, 1'b0,
                    nrd, nwr, lrd, lwr);
            check("rand_nrd", 32'(nrd),
                  (w >= 3 && l >= 3) ? 32'(9 * (w - 2) * (l - 2)) : 32'd0);
            check("rand_nwr", 32'(nwr),
                  (w >= 3 && l >= 3) ? 32'((w - 2) * (l - 2)) : 32'd0);
        end

        // Reset in the middle of a read wait, then a clean job.
        @(negedge HCLK);
        start = 1'b1;
        width = 12'd4;
        length = 12'd4;
        initial_addr_r = 8'h50;
        initial_addr_w = 8'h60;
        @(negedge HCLK);
        start = 1'b0;
        check("midrd_req", {31'd0, mif.rd_req}, 32'd1);
        check("midrd_busy", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        check_idle_outputs("midreset");
        HRESET = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK);
            check("no_done_after_reset", {30'd0, done, busy}, 32'd0);
        end
        run_job(3, 3, 8'h10, 8'h80, 0, 1, 1'b0, nrd, nwr, lrd, lwr);
        check("post_reset_nrd", 32'(nrd), 32'd9);
        check("post_reset_lwr", lwr, 32'h80);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_controller.md
FRAME_CONTROLLER -- requirements
Module: frame_controller

Interface
REQ-001 SHALL provide ports: HCLK  in  1  sole clock, all state updates on its rising edge.
REQ-002 SHALL provide: HRESET  in  1  reset, synchronous and active-low.
REQ-003 SHALL provide: start  in  1  job request level from the AHB slave stage.
REQ-004 SHALL provide: width  in  12  frame width in pixels; length  in  12  frame height in pixels.
REQ-005 SHALL provide: initial_addr_r  in  8  source base; initial_addr_w  in  8  destination base.
REQ-006 SHALL provide: rd_req  out  1;  rd_addr  out  32;  rd_ack  in  1  (read handshake).
REQ-007 SHALL provide: wr_req  out  1;  wr_addr  out  32;  wr_ack  in  1  (write handshake).
REQ-008 SHALL provide: busy  out  1;  done  out  1 (1-cycle pulse);  err  out  1 (1-cycle pulse).

Function
REQ-009 SHALL implement states IDLE, READ, WRITE, FINISH; all outputs registered.
REQ-010 SHALL, in IDLE with start=1, latch width, length and both bases; start in any other state is ignored.
REQ-011 SHALL, if latched width<3 or length<3, pulse err for one cycle and remain in IDLE with no requests.
REQ-012 SHALL otherwise enter READ the cycle after acceptance with busy=1 and rd_req=1.
REQ-013 SHALL visit output pixels (x,y), x=1..width-2, y=1..length-2, x fastest.
REQ-014 SHALL per pixel issue 9 reads, rows y-1..y+1, cols x-1..x+1, row-major order.
REQ-015 SHALL form rd_addr = initial_addr_r (zero-extended) + row*width + col, modulo 2^32.
REQ-016 SHALL hold rd_req and rd_addr stable until the cycle rd_ack=1; next read presented the following cycle.
REQ-017 SHALL after the 9th rd_ack enter WRITE with wr_req=1, wr_addr = initial_addr_w + (y-1)*(width-2) + (x-1), modulo 2^32.
REQ-018 SHALL hold wr_req/wr_addr until wr_ack=1; then advance pixel and return to READ, or go to FINISH after last pixel.
REQ-019 SHALL in FINISH pulse done for exactly one cycle, drop busy, return to IDLE.
REQ-020 SHALL ignore rd_ack outside READ and wr_ack outside WRITE; rd_req and wr_req never high together.

Reset
REQ-021 SHALL on HRESET=0 at a clock edge force IDLE, rd_req=0, wr_req=0, rd_addr=0, wr_addr=0, busy=0, done=0, err=0, clear counters.
REQ-022 SHALL abandon any in-flight job on reset; no done pulse is produced for it.

Configuration
REQ-023 SHALL, with FRAME_CTRL_PERF_CNT_EN defined, add output cycle_count  out  32: cleared on job acceptance, +1 per busy cycle, held after done, reset to 0.
REQ-024 SHALL, without FRAME_CTRL_PERF_CNT_EN, omit the cycle_count port and its logic entirely.

Structure
REQ-025 SHALL place the state enum, WIN_SIZE=9 and MIN_DIM=3 in shared package sobel_pkg.
REQ-026 SHALL implement x/y/window-index counters and address arithmetic in sub-module pixel_cursor.

Verification
REQ-027 SHALL test 3x3, bases 0x10/0x80, immediate acks -> reads 0x10..0x12,0x13..0x15,0x16..0x18, one write 0x80, one done pulse.
REQ-028 SHALL test 4x3, bases 0x00/0x40 -> 18 reads, writes 0x40 then 0x41, then done.
REQ-029 SHALL test width=2, length=5 -> err pulse one cycle, no rd_req/wr_req, busy stays 0.
REQ-030 SHALL test rd_ack delayed 5 cycles -> rd_req and rd_addr stable all 5 cycles.
REQ-031 SHALL test HRESET=0 mid-READ -> all outputs 0 next cycle; new start then runs cleanly.
REQ-032 SHALL test start reasserted with different width while busy -> ignored, original job addresses unchanged.
